// File: rtl/ctx_save_restore.sv
// ctx_save_restore
// Pushes or pops an exception context (CPSR, PC, LR) on a full-descending
// stack through a single-word handshake memory port. It then commits the
// updated special registers through one-cycle write strobes.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   save_req, restore_req         start a context push / pop (sampled in IDLE only)
//   re_sp/re_lr/re_pc/re_cpsr     current special-register values
//   vector_addr                   PC target committed after a save
//   mem_req/mem_we/mem_addr/mem_wdata   registered word request (we=1 write)
//   mem_ack/mem_rdata             word completion and read data
//   wr_*/wr_*_data                one-cycle register write strobes and data
//   busy                          high whenever not IDLE
//   done/error                    completion / ack-timeout abort pulses
module ctx_save_restore #(
  parameter logic [31:0] CPSR_CLR_MASK = 32'h0000_0001,
  parameter int          ACK_TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        save_req,
  input  logic        restore_req,
  input  logic [31:0] re_sp,
  input  logic [31:0] re_lr,
  input  logic [31:0] re_pc,
  input  logic [31:0] re_cpsr,
  input  logic [31:0] vector_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        wr_sp,
  output logic        wr_lr,
  output logic        wr_pc,
  output logic        wr_cpsr,
  output logic [31:0] wr_sp_data,
  output logic [31:0] wr_lr_data,
  output logic [31:0] wr_pc_data,
  output logic [31:0] wr_cpsr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    SAVE_COMMIT,
    RESTORE,
    RESTORE_COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_n;
  logic [CNT_W-1:0] wait_q;
  logic             error_q;

  // Snapshot of the context taken at accept; in RESTORE, lr/pc/cpsr hold the popped words.
  logic [31:0] sp_q, lr_q, pc_q, cpsr_q, vec_q;

  logic xfer, word_ack, last_ack, timeout, accept_save, accept_restore;

  // Full-descending push order: word 0 sits just below SP.
  function automatic logic [31:0] save_addr(input logic [31:0] sp, input logic [1:0] i);
    case (i)
      2'd0:    save_addr = sp - 32'd4;
      2'd1:    save_addr = sp - 32'd8;
      default: save_addr = sp - 32'd12;
    endcase
  endfunction

  function automatic logic [31:0] restore_addr(input logic [31:0] sp, input logic [1:0] i);
    restore_addr = sp + {28'd0, i, 2'b00};
  endfunction

  function automatic logic [31:0] save_word(input logic [1:0] i, input logic [31:0] cpsr,
                                            input logic [31:0] pc, input logic [31:0] lr);
    case (i)
      2'd0:    save_word = cpsr;
      2'd1:    save_word = pc;
      default: save_word = lr;
    endcase
  endfunction

  always_comb begin
    xfer           = (state_q == SAVE) || (state_q == RESTORE);
    word_ack       = xfer && mem_req && mem_ack;
    last_ack       = word_ack && (idx_q == 2'd2);
    timeout        = xfer && mem_req && !mem_ack && (wait_q == CNT_W'(ACK_TIMEOUT - 1));
    accept_save    = (state_q == IDLE) && save_req;
    accept_restore = (state_q == IDLE) && !save_req && restore_req;
    idx_n          = idx_q + 2'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_save)         state_d = SAVE;
        else if (accept_restore) state_d = RESTORE;
      end
      SAVE: begin
        if (timeout)       state_d = IDLE;
        else if (last_ack) state_d = SAVE_COMMIT;
      end
      RESTORE: begin
        if (timeout)       state_d = IDLE;
        else if (last_ack) state_d = RESTORE_COMMIT;
      end
      SAVE_COMMIT:    state_d = IDLE;
      RESTORE_COMMIT: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Memory request channel: registered, held until the acked edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= timeout;
      if (accept_save) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= re_sp - 32'd4;
        mem_wdata <= re_cpsr;
        idx_q     <= '0;
        wait_q    <= '0;
      end else if (accept_restore) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= re_sp;
        mem_wdata <= '0;
        idx_q     <= '0;
        wait_q    <= '0;
      end else if (last_ack || timeout) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        idx_q     <= '0;
        wait_q    <= '0;
      end else if (word_ack) begin
        // Next word is issued on the same edge so acks can stream without a bubble.
        idx_q  <= idx_n;
        wait_q <= '0;
        if (state_q == SAVE) begin
          mem_addr  <= save_addr(sp_q, idx_n);
          mem_wdata <= save_word(idx_n, cpsr_q, pc_q, lr_q);
        end else begin
          mem_addr  <= restore_addr(sp_q, idx_n);
        end
      end else if (xfer && mem_req) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  // Context snapshot and popped words.
  always_ff @(posedge clk) begin
    if (accept_save) begin
      sp_q   <= re_sp;
      lr_q   <= re_lr;
      pc_q   <= re_pc;
      cpsr_q <= re_cpsr;
      vec_q  <= vector_addr;
    end else if (accept_restore) begin
      sp_q   <= re_sp;
    end else if (word_ack && (state_q == RESTORE)) begin
      case (idx_q)
        2'd0:    lr_q   <= mem_rdata;
        2'd1:    pc_q   <= mem_rdata;
        default: cpsr_q <= mem_rdata;
      endcase
    end
  end

  always_comb begin
    wr_sp        = 1'b0;
    wr_lr        = 1'b0;
    wr_pc        = 1'b0;
    wr_cpsr      = 1'b0;
    wr_sp_data   = '0;
    wr_lr_data   = '0;
    wr_pc_data   = '0;
    wr_cpsr_data = '0;
    done         = 1'b0;
    busy         = (state_q != IDLE);
    error        = error_q;
    case (state_q)
      SAVE_COMMIT: begin
        // LR is left alone: the handler keeps the caller's LR.
        wr_sp        = 1'b1;
        wr_pc        = 1'b1;
        wr_cpsr      = 1'b1;
        wr_sp_data   = sp_q - 32'd12;
        wr_pc_data   = vec_q;
        wr_cpsr_data = cpsr_q & ~CPSR_CLR_MASK;
        done         = 1'b1;
      end
      RESTORE_COMMIT: begin
        wr_sp        = 1'b1;
        wr_lr        = 1'b1;
        wr_pc        = 1'b1;
        wr_cpsr      = 1'b1;
        wr_sp_data   = sp_q + 32'd12;
        wr_lr_data   = lr_q;
        wr_pc_data   = pc_q;
        wr_cpsr_data = cpsr_q;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctx_save_restore.sv
// Randomized scoreboard bench for ctx_save_restore. The stimulus process
// predicts every memory word, commit and abort from a register/memory model,
// and queues them. A negedge monitor pops and compares whatever the DUT presents.
module tb_ctx_save_restore;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_req, restore_req;
  logic [31:0] re_sp, re_lr, re_pc, re_cpsr, vector_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        wr_sp, wr_lr, wr_pc, wr_cpsr;
  logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data, wr_cpsr_data;
  logic        busy, done, error;

  ctx_save_restore #(.CPSR_CLR_MASK(32'h0000_0001), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .re_sp(re_sp), .re_lr(re_lr), .re_pc(re_pc), .re_cpsr(re_cpsr),
    .vector_addr(vector_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_sp(wr_sp), .wr_lr(wr_lr), .wr_pc(wr_pc), .wr_cpsr(wr_cpsr),
    .wr_sp_data(wr_sp_data), .wr_lr_data(wr_lr_data), .wr_pc_data(wr_pc_data),
    .wr_cpsr_data(wr_cpsr_data), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural model of the register file and stack memory.
  logic [31:0] m_sp, m_lr, m_pc, m_cpsr;
  logic [31:0] mem [logic [31:0]];
  assign re_sp   = m_sp;
  assign re_lr   = m_lr;
  assign re_pc   = m_pc;
  assign re_cpsr = m_cpsr;

  typedef struct {
    int          kind;   // 0 memory word, 1 commit, 2 abort
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  stb;    // {sp, lr, pc, cpsr}
    logic [1:0]  flg;    // {done, error}
    logic [31:0] d_sp, d_lr, d_pc, d_cpsr;
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (mem_req && mem_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_mem_word", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("mem_kind", 64'd0, 64'(e.kind));
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
          chk("mem_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (mem_req && q.size() > 0 && q[0].kind == 0) begin
        chk("hold_addr", 64'(mem_addr), 64'(q[0].addr));
        chk("hold_we", 64'(mem_we), 64'(q[0].we));
        if (q[0].we) chk("hold_wdata", 64'(mem_wdata), 64'(q[0].wdata));
      end
      if (done || error || wr_sp || wr_lr || wr_pc || wr_cpsr) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {58'd0, done, error, wr_sp, wr_lr, wr_pc, wr_cpsr}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("pulse_flags", 64'({done, error}), 64'(e.flg));
          chk("pulse_strobes", 64'({wr_sp, wr_lr, wr_pc, wr_cpsr}), 64'(e.stb));
          chk("wr_sp_data", 64'(wr_sp_data), 64'(e.d_sp));
          chk("wr_lr_data", 64'(wr_lr_data), 64'(e.d_lr));
          chk("wr_pc_data", 64'(wr_pc_data), 64'(e.d_pc));
          chk("wr_cpsr_data", 64'(wr_cpsr_data), 64'(e.d_cpsr));
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({mem_req, mem_we, busy, done, error, wr_sp, wr_lr, wr_pc, wr_cpsr}), 64'd0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    chk({tag, "_wd0"}, {wr_sp_data, wr_lr_data}, 64'd0);
    chk({tag, "_wd1"}, {wr_pc_data, wr_cpsr_data}, 64'd0);
  endtask

  task automatic wait_cycle();
    mem_ack     = 1'b0;
    mem_rdata   = $urandom;
    save_req    = 1'($urandom_range(0, 1));
    restore_req = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  // fail_word: -1 none; otherwise the word index that never gets its ack
  // (abort by timeout) or during which reset is applied (fail_is_rst).
  task automatic run_op(input bit is_save, input bit both, input logic [31:0] vec,
                        input int w0, input int w1, input int w2,
                        input int fail_word, input bit fail_is_rst);
    int          w[3];
    logic [31:0] a[3], d[3];
    logic [31:0] n_sp, n_lr, n_pc, n_cpsr;
    ev_t         e;
    int          t, nwords;
    bit          stop;
    w = '{w0, w1, w2};
    nwords = (fail_word < 0) ? 3 : fail_word;
    for (int k = 0; k < 3; k++) begin
      if (is_save) begin
        a[k] = m_sp - 32'(4 * (k + 1));
        d[k] = (k == 0) ? m_cpsr : (k == 1) ? m_pc : m_lr;
      end else begin
        a[k] = m_sp + 32'(4 * k);
        d[k] = rd_mem(a[k]);
      end
    end
    t = cyc + 1;
    for (int k = 0; k < nwords; k++) begin
      e = '{default: '0};
      e.kind = 0; e.we = is_save; e.addr = a[k]; e.wdata = d[k]; e.cyc = t + w[k];
      q.push_back(e);
      if (is_save) mem[a[k]] = d[k];
      t += w[k] + 1;
    end
    if (is_save) begin
      n_sp = m_sp - 32'd12; n_lr = m_lr; n_pc = vec; n_cpsr = m_cpsr & ~32'h1;
    end else begin
      n_sp = m_sp + 32'd12; n_lr = d[0]; n_pc = d[1]; n_cpsr = d[2];
    end
    if (fail_word < 0) begin
      e = '{default: '0};
      e.kind = 1; e.flg = 2'b10; e.cyc = t;
      e.stb  = is_save ? 4'b1011 : 4'b1111;
      e.d_sp = n_sp; e.d_lr = is_save ? 32'd0 : n_lr; e.d_pc = n_pc; e.d_cpsr = n_cpsr;
      q.push_back(e);
    end else if (!fail_is_rst) begin
      e = '{default: '0};
      e.kind = 2; e.flg = 2'b01; e.cyc = t + TO;
      q.push_back(e);
    end

    save_req    = is_save;
    restore_req = !is_save || both;
    vector_addr = vec;
    @(posedge clk); #1;
    save_req    = 1'b0;
    restore_req = 1'b0;
    vector_addr = $urandom;
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!stop) begin
        if (k == fail_word && fail_is_rst) begin
          repeat (2) wait_cycle();
          save_req = 1'b0; restore_req = 1'b1; reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0; restore_req = 1'b0;
          chk_all_zero("reset_mid_op");
          stop = 1'b1;
        end else if (k == fail_word) begin
          repeat (TO) wait_cycle();
          save_req = 1'b0; restore_req = 1'b0;
          chk("busy_after_abort", 64'(busy), 64'd0);
          stop = 1'b1;
        end else begin
          repeat (w[k]) wait_cycle();
          mem_ack     = 1'b1;
          mem_rdata   = is_save ? $urandom : d[k];
          save_req    = 1'b0;
          restore_req = 1'b0;
          @(posedge clk); #1;
          mem_ack = 1'b0;
        end
      end
    end
    if (fail_word < 0) begin
      mem_ack = 1'($urandom_range(0, 1));   // stray ack in commit cycle
      @(posedge clk); #1;
      mem_ack = 1'b0;
      m_sp = n_sp; m_lr = n_lr; m_pc = n_pc; m_cpsr = n_cpsr;
    end
    repeat ($urandom_range(0, 2)) begin
      mem_ack = 1'($urandom_range(0, 1));   // stray ack while idle
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int to_word;
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0; vector_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    m_sp = 32'h1000; m_lr = 32'h44; m_pc = 32'h80; m_cpsr = 32'hF1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    save_req = 1'b1;                        // reset must dominate a request
    @(posedge clk); #1;
    reset = 1'b0; save_req = 1'b0;
    chk("busy_reset_dominates", 64'(busy), 64'd0);

    run_op(1'b1, 1'b0, 32'h200, 0, 0, 0, -1, 1'b0);    // save, zero wait
    run_op(1'b0, 1'b0, 32'h0,   0, 0, 0, -1, 1'b0);    // restore it back
    run_op(1'b1, 1'b0, 32'h300, 3, 3, 3, -1, 1'b0);    // waited save
    run_op(1'b1, 1'b0, 32'h400, 0, 0, 0,  1, 1'b0);    // timeout on word 1
    run_op(1'b1, 1'b1, 32'h500, 2, 1, 0, -1, 1'b0);    // both requests
    m_sp = 32'h0000_0004;
    run_op(1'b1, 1'b0, 32'h600, 0, 1, 0, -1, 1'b0);    // address wrap
    run_op(1'b0, 1'b0, 32'h0,   0, 0, 0,  1, 1'b1);    // reset mid-restore

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        m_sp = $urandom & 32'hFFFF_FFFC; m_lr = $urandom; m_pc = $urandom; m_cpsr = $urandom;
      end
      to_word = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
             to_word, 1'b0);
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
